// File: rtl/pic_core_param.sv
// pic_core_param: multi-cycle PIC-style core with a 14-bit instruction word,
// a direct-addressed file-register RAM, Z/C flags and GOTO.
// All state changes on the falling clock edge. The instruction ROM is external
// and combinational on rom_addr.
// Build option: define PIC_CORE_STEP_EN to add run/step single-step control.
module pic_core_param #(
    parameter int PC_W   = 11,
    parameter int RAM_AW = 7
) (
    input  logic            clk,
    input  logic            reset,
`ifdef PIC_CORE_STEP_EN
    input  logic            run,
    input  logic            step,
`endif
    output logic [PC_W-1:0] rom_addr,
    input  logic [13:0]     rom_data,
    output logic [7:0]      w_output,
    output logic [PC_W-1:0] pc_output,
    output logic            z_flag,
    output logic            c_flag,
    output logic [2:0]      state_output
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   mar_q, mar_d;
    logic [13:0]       ir_q, ir_d;
    logic [7:0]        w_q, w_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [7:0]        ram_q [RAM_DEPTH];
    logic              ram_we;

    // Instruction fields
    logic [5:0]        op6;
    logic [6:0]        op7;
    logic [7:0]        k;
    logic              dbit;
    logic [RAM_AW-1:0] faddr;
    logic [7:0]        fval;

    // Execute-stage results
    logic [7:0]        res;
    logic              cy;
    logic              wr_w, wr_f, upd_z, upd_c, jump, byte_op;

    // Leaving the T1 fetch slot is gated only in the single-step build
    logic              advance;

`ifdef PIC_CORE_STEP_EN
    assign advance = run | step;
`else
    assign advance = 1'b1;
`endif

    assign op6   = ir_q[13:8];
    assign op7   = ir_q[13:7];
    assign k     = ir_q[7:0];
    assign dbit  = ir_q[7];
    assign faddr = ir_q[RAM_AW-1:0];
    assign fval  = ram_q[faddr];

    // 8-bit add; bit 8 is the carry out of bit 7
    function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // 8-bit subtract a-b; bit 8 is the PIC carry (1 = no borrow, a >= b)
    function automatic logic [8:0] sub9(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return {~diff[8], diff[7:0]};
    endfunction

    // Decode the held instruction into a result and its write/flag enables
    always_comb begin
        res     = 8'd0;
        cy      = 1'b0;
        wr_w    = 1'b0;
        wr_f    = 1'b0;
        upd_z   = 1'b0;
        upd_c   = 1'b0;
        jump    = 1'b0;
        byte_op = 1'b0;
        if (ir_q[13:11] == 3'b101) begin
            jump = 1'b1;
        end else if (op7 == 7'b0000001) begin
            res  = w_q;
            wr_f = 1'b1;
        end else if (op7 == 7'b0000011) begin
            res   = 8'd0;
            wr_f  = 1'b1;
            upd_z = 1'b1;
        end else begin
            case (op6)
                6'h30: begin res = k; wr_w = 1'b1; end
                6'h3E: begin {cy, res} = add9(k, w_q); wr_w = 1'b1; upd_z = 1'b1; upd_c = 1'b1; end
                6'h3C: begin {cy, res} = sub9(k, w_q); wr_w = 1'b1; upd_z = 1'b1; upd_c = 1'b1; end
                6'h39: begin res = k & w_q; wr_w = 1'b1; upd_z = 1'b1; end
                6'h38: begin res = k | w_q; wr_w = 1'b1; upd_z = 1'b1; end
                6'h3A: begin res = k ^ w_q; wr_w = 1'b1; upd_z = 1'b1; end
                6'h07: begin {cy, res} = add9(fval, w_q); byte_op = 1'b1; upd_c = 1'b1; end
                6'h02: begin {cy, res} = sub9(fval, w_q); byte_op = 1'b1; upd_c = 1'b1; end
                6'h05: begin res = fval & w_q;  byte_op = 1'b1; end
                6'h04: begin res = fval | w_q;  byte_op = 1'b1; end
                6'h06: begin res = fval ^ w_q;  byte_op = 1'b1; end
                6'h08: begin res = fval;        byte_op = 1'b1; end
                6'h0A: begin res = fval + 8'd1; byte_op = 1'b1; end
                6'h03: begin res = fval - 8'd1; byte_op = 1'b1; end
                default: ;
            endcase
            if (byte_op) begin
                wr_w  = ~dbit;
                wr_f  = dbit;
                upd_z = 1'b1;
            end
        end
    end

    // Fetch/execute sequencer: next state and register loads per step
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        w_d     = w_q;
        z_d     = z_q;
        c_d     = c_q;
        ram_we  = 1'b0;
        case (state_q)
            T0: state_d = T1;
            T1: begin
                if (advance) begin
                    mar_d   = pc_q;
                    state_d = T2;
                end
            end
            T2: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = T3;
            end
            T3: begin
                ir_d    = rom_data;
                state_d = T4;
            end
            T4: begin
                if (jump)  pc_d = ir_q[PC_W-1:0];
                if (wr_w)  w_d  = res;
                if (upd_z) z_d  = (res == 8'd0);
                if (upd_c) c_d  = cy;
                ram_we  = wr_f;
                state_d = T5;
            end
            T5: state_d = T6;
            T6: state_d = T1;
            default: state_d = T1;
        endcase
    end

    // Falling-edge state and register file, cleared asynchronously by reset
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T0;
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            w_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            w_q     <= w_d;
            z_q     <= z_d;
            c_q     <= c_d;
            if (ram_we) ram_q[faddr] <= res;
        end
    end

    assign rom_addr     = mar_q;
    assign w_output     = w_q;
    assign pc_output    = pc_q;
    assign z_flag       = z_q;
    assign c_flag       = c_q;
    assign state_output = state_q;

endmodule
